// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter
//   Owns all main-memory traffic for the I-cache and D-cache. Grants one
//   requester at a time (D miss > D store > I miss), issues the block read
//   word by word, steers returning words into the owning cache's data array,
//   pulses the fill-done / store-ack handshakes and drives the stall requests.
//
//   state | meaning
//   IDLE  | accept a new request; stores complete here in a single cycle
//   FILL  | issue block reads and route returning words to the owner
//   DONE  | one cycle: pulse owner's fill_done, clear counters
//
// Ports
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_I_miss / i_I_miss_addr      I-cache miss request and faulting address
//   i_D_miss / i_D_miss_addr      D-cache miss request and faulting address
//   i_D_write / i_D_wr_*          write-through store request
//   o_mem_* / i_mem_*             main-memory request and read-return
//   o_fill_I/D, o_fill_idx/data   data-array write port toward the caches
//   o_*_fill_done, o_D_wr_ack     completion pulses
//   o_I_stall, o_D_stall          stall requests to hazard detection
module mem_fill_arbiter #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int WORDS_PER_BLK = 8,
    parameter int MEM_LAT       = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_I_miss,
    input  logic [ADDR_W-1:0]                i_I_miss_addr,
    input  logic                             i_D_miss,
    input  logic [ADDR_W-1:0]                i_D_miss_addr,
    input  logic                             i_D_write,
    input  logic [ADDR_W-1:0]                i_D_wr_addr,
    input  logic [DATA_W-1:0]                i_D_wr_data,
    output logic                             o_mem_en,
    output logic                             o_mem_wr,
    output logic [ADDR_W-1:0]                o_mem_addr,
    output logic [DATA_W-1:0]                o_mem_wdata,
    input  logic [DATA_W-1:0]                i_mem_rdata,
    input  logic                             i_mem_data_valid,
    output logic                             o_fill_I,
    output logic                             o_fill_D,
    output logic [$clog2(WORDS_PER_BLK)-1:0] o_fill_idx,
    output logic [DATA_W-1:0]                o_fill_data,
    output logic                             o_I_fill_done,
    output logic                             o_D_fill_done,
    output logic                             o_D_wr_ack,
    output logic                             o_I_stall,
    output logic                             o_D_stall
);

    localparam int IDX_W = $clog2(WORDS_PER_BLK);
    // Byte offset mask of one block (words are 2 bytes wide).
    localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(2 * WORDS_PER_BLK - 1);

    if ((WORDS_PER_BLK != (1 << IDX_W)) || (MEM_LAT < 1)) begin : g_param_check
        $error("mem_fill_arbiter: WORDS_PER_BLK must be a power of 2 and MEM_LAT >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_owner_d;
    logic [ADDR_W-1:0] r_base;
    logic [IDX_W:0]    r_iss_cnt;   // one extra bit so it can reach WORDS_PER_BLK
    logic [IDX_W-1:0]  r_rcv_cnt;

    logic              w_idle;
    logic              w_fill;
    logic              w_done;
    logic              w_grant_d;
    logic              w_grant_i;
    logic              w_store;
    logic              w_issue;
    logic              w_recv;
    logic              w_last;
    logic [ADDR_W-1:0] w_rd_addr;

    // Everything is gated by reset so nothing transacts while it is held.
    assign w_idle    = (r_state == S_IDLE) & ~i_rst;
    assign w_fill    = (r_state == S_FILL) & ~i_rst;
    assign w_done    = (r_state == S_DONE) & ~i_rst;

    assign w_grant_d = w_idle & i_D_miss;
    assign w_store   = w_idle & ~i_D_miss & i_D_write;
    assign w_grant_i = w_idle & ~i_D_miss & ~i_D_write & i_I_miss;

    assign w_issue   = w_fill & ~r_iss_cnt[IDX_W];
    assign w_recv    = w_fill & i_mem_data_valid;
    assign w_last    = w_recv & (r_rcv_cnt == IDX_W'(WORDS_PER_BLK - 1));

    // Base is block-aligned, so the add never carries out of the block.
    assign w_rd_addr = r_base + {{(ADDR_W-IDX_W-1){1'b0}}, r_iss_cnt[IDX_W-1:0], 1'b0};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_owner_d <= 1'b0;
            r_base    <= '0;
            r_iss_cnt <= '0;
            r_rcv_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_d) begin
                        r_owner_d <= 1'b1;
                        r_base    <= i_D_miss_addr & ~BLK_MASK;
                        r_state   <= S_FILL;
                    end else if (w_grant_i) begin
                        r_owner_d <= 1'b0;
                        r_base    <= i_I_miss_addr & ~BLK_MASK;
                        r_state   <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (w_issue) r_iss_cnt <= r_iss_cnt + 1'b1;
                    if (w_recv)  r_rcv_cnt <= r_rcv_cnt + 1'b1;
                    if (w_last)  r_state   <= S_DONE;
                end
                S_DONE: begin
                    r_iss_cnt <= '0;
                    r_rcv_cnt <= '0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_mem_en      = w_issue | w_store;
        o_mem_wr      = w_store;
        o_mem_addr    = w_store ? i_D_wr_addr : (w_issue ? w_rd_addr : '0);
        o_mem_wdata   = w_store ? i_D_wr_data : '0;
        o_fill_I      = w_recv & ~r_owner_d;
        o_fill_D      = w_recv & r_owner_d;
        o_fill_idx    = w_recv ? r_rcv_cnt : '0;
        o_fill_data   = w_recv ? i_mem_rdata : '0;
        o_I_fill_done = w_done & ~r_owner_d;
        o_D_fill_done = w_done & r_owner_d;
        o_D_wr_ack    = w_store;
        o_I_stall     = ~i_rst & i_I_miss & ~o_I_fill_done;
        o_D_stall     = ~i_rst & ((i_D_miss & ~o_D_fill_done) | (i_D_write & ~o_D_wr_ack));
    end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
module tb_mem_fill_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, i_miss, d_miss, d_write, mem_dv;
    logic [15:0] i_addr, d_addr, w_addr, w_data, mem_rdata;
    logic        o_mem_en, o_mem_wr, o_fill_I, o_fill_D, o_I_done, o_D_done, o_ack, o_I_stall, o_D_stall;
    logic [15:0] o_mem_addr, o_mem_wdata, o_fill_data;
    logic [2:0]  o_fill_idx;

    mem_fill_arbiter dut (
        .i_clk(clk), .i_rst(rst),
        .i_I_miss(i_miss), .i_I_miss_addr(i_addr),
        .i_D_miss(d_miss), .i_D_miss_addr(d_addr),
        .i_D_write(d_write), .i_D_wr_addr(w_addr), .i_D_wr_data(w_data),
        .o_mem_en(o_mem_en), .o_mem_wr(o_mem_wr), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(mem_rdata), .i_mem_data_valid(mem_dv),
        .o_fill_I(o_fill_I), .o_fill_D(o_fill_D), .o_fill_idx(o_fill_idx), .o_fill_data(o_fill_data),
        .o_I_fill_done(o_I_done), .o_D_fill_done(o_D_done), .o_D_wr_ack(o_ack),
        .o_I_stall(o_I_stall), .o_D_stall(o_D_stall)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // memory: each read returns 4 cycles after issue
    int          due_q[$];
    logic [15:0] adr_q[$];

    // transaction-level reference: one active fill with its start cycle
    bit          m_busy, m_own_d;
    int          m_t0;
    logic [15:0] m_base;
    bit          x_done_i, x_done_d, x_ack;

    int          obs_done_i, obs_done_d, obs_ack, fill_seen;
    logic [15:0] obs_last_rd;

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return (a * 16'd7) ^ 16'h5A3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        logic        e_en, e_wr, e_fi, e_fd, e_di, e_dd, e_ack, e_is, e_ds;
        logic [15:0] e_addr, e_wd, e_fdata;
        logic [2:0]  e_idx;
        int          k;
        @(negedge clk);
        {e_en, e_wr, e_fi, e_fd, e_di, e_dd, e_ack, e_is, e_ds} = '0;
        e_addr = '0; e_wd = '0; e_fdata = '0; e_idx = '0;
        if (rst) begin
            m_busy = 1'b0;
        end else begin
            if (!m_busy) begin
                if (d_miss) begin
                    m_busy = 1'b1; m_own_d = 1'b1; m_t0 = cyc; m_base = d_addr & 16'hFFF0;
                end else if (d_write) begin
                    e_en = 1'b1; e_wr = 1'b1; e_addr = w_addr; e_wd = w_data; e_ack = 1'b1;
                end else if (i_miss) begin
                    m_busy = 1'b1; m_own_d = 1'b0; m_t0 = cyc; m_base = i_addr & 16'hFFF0;
                end
            end else begin
                k = cyc - m_t0;
                if (k >= 1 && k <= 8) begin
                    e_en = 1'b1; e_addr = m_base + 16'(2 * (k - 1));
                end
                if (k >= 5 && k <= 12) begin
                    e_fi = !m_own_d; e_fd = m_own_d; e_idx = 3'(k - 5);
                    e_fdata = mem_val(m_base + 16'(2 * (k - 5)));
                end
                if (k == 13) begin
                    e_di = !m_own_d; e_dd = m_own_d; m_busy = 1'b0;
                end
            end
            e_is = i_miss & ~e_di;
            e_ds = (d_miss & ~e_dd) | (d_write & ~e_ack);
        end
        chk("mem_en", o_mem_en, e_en);
        chk("mem_wr", o_mem_wr, e_wr);
        chk("mem_addr", o_mem_addr, e_addr);
        chk("mem_wdata", o_mem_wdata, e_wd);
        chk("fill_I", o_fill_I, e_fi);
        chk("fill_D", o_fill_D, e_fd);
        chk("fill_idx", o_fill_idx, e_idx);
        chk("fill_data", o_fill_data, e_fdata);
        chk("I_fill_done", o_I_done, e_di);
        chk("D_fill_done", o_D_done, e_dd);
        chk("D_wr_ack", o_ack, e_ack);
        chk("I_stall", o_I_stall, e_is);
        chk("D_stall", o_D_stall, e_ds);
        x_done_i = e_di; x_done_d = e_dd; x_ack = e_ack;
        if (o_I_done) obs_done_i = cyc;
        if (o_D_done) obs_done_d = cyc;
        if (o_ack) obs_ack = cyc;
        if (o_fill_I || o_fill_D) fill_seen++;
        if (o_mem_en && !o_mem_wr) begin
            obs_last_rd = o_mem_addr;
            due_q.push_back(cyc + 4);
            adr_q.push_back(o_mem_addr);
        end
        @(posedge clk);
        #1;
        cyc++;
        mem_dv = 1'b0;
        mem_rdata = 16'($urandom);
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            mem_dv = 1'b1;
            mem_rdata = mem_val(adr_q[0]);
            void'(due_q.pop_front());
            void'(adr_q.pop_front());
        end
        // caches release their requests once served
        if (x_done_i) i_miss = 1'b0;
        if (x_done_d) d_miss = 1'b0;
        if (x_ack) d_write = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((i_miss || d_miss || d_write || m_busy) && n < 200) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(i_miss | d_miss | d_write | m_busy), 32'd0);
    endtask

    task automatic clear_obs();
        obs_done_i = -1; obs_done_d = -1; obs_ack = -1; fill_seen = 0; obs_last_rd = '0;
    endtask

    int t0;

    initial begin
        rst = 1'b1; i_miss = 0; d_miss = 0; d_write = 0; mem_dv = 0;
        i_addr = '0; d_addr = '0; w_addr = '0; w_data = '0; mem_rdata = '0;
        m_busy = 0; m_own_d = 0; m_t0 = 0; m_base = '0;
        clear_obs();
        step(); step();
        rst = 1'b0;
        step(); step();

        // 1: D miss timing
        clear_obs();
        d_miss = 1; d_addr = 16'h1236; t0 = cyc;
        drain();
        chk("t1_done_cycle", obs_done_d - t0, 13);
        chk("t1_last_rd", obs_last_rd, 16'h123E);

        // 2: simultaneous I and D misses
        clear_obs();
        i_miss = 1; i_addr = 16'h2008; d_miss = 1; d_addr = 16'h3000; t0 = cyc;
        drain();
        chk("t2_d_done", obs_done_d - t0, 13);
        chk("t2_i_done", obs_done_i - t0, 27);

        // 3: store during I fill waits for IDLE
        clear_obs();
        i_miss = 1; i_addr = 16'h0100; t0 = cyc;
        step(); step(); step();
        d_write = 1; w_addr = 16'h0040; w_data = 16'hBEEF;
        drain();
        chk("t3_ack_cycle", obs_ack - t0, 14);

        // 4: reset in the middle of a D fill
        clear_obs();
        d_miss = 1; d_addr = 16'h1236; t0 = cyc;
        for (int i = 0; i < 6; i++) step();
        rst = 1; d_miss = 0;
        step();
        rst = 0;
        fill_seen = 0;
        for (int i = 0; i < 8; i++) step();
        chk("t4_no_stray_fill", fill_seen, 0);
        i_miss = 1; i_addr = 16'h0A0A; t0 = cyc;
        drain();
        chk("t4_i_done", obs_done_i - t0, 13);

        // 5: top-of-memory block
        clear_obs();
        i_miss = 1; i_addr = 16'hFFFE; t0 = cyc;
        drain();
        chk("t5_last_rd", obs_last_rd, 16'hFFFE);

        // 6: flushed miss still completes; lone store is single-cycle
        clear_obs();
        d_miss = 1; d_addr = 16'h4444; t0 = cyc;
        step(); step(); step();
        d_miss = 0;
        drain();
        chk("t6_d_done", obs_done_d - t0, 13);
        d_write = 1; w_addr = 16'h0012; w_data = 16'h7777; t0 = cyc;
        step();
        chk("t6_ack_same", obs_ack - t0, 0);
        step();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            if (!i_miss && !(m_busy && !m_own_d) && $urandom_range(7) == 0) begin
                i_miss = 1; i_addr = 16'($urandom);
            end
            if (!d_miss && !(m_busy && m_own_d) && $urandom_range(9) == 0) begin
                d_miss = 1; d_addr = 16'($urandom);
            end
            if (!d_write && $urandom_range(5) == 0) begin
                d_write = 1; w_addr = 16'($urandom); w_data = 16'($urandom);
            end
            if (d_miss && m_busy && m_own_d && $urandom_range(39) == 0) d_miss = 0;
            step();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
